// File: rtl/hps_fifo_writer.sv
// HPS-facing Avalon-MM slave that pushes words into three downstream FIFOs,
// tracks their occupancy, and drops writes that stay blocked too long.
module hps_fifo_writer #(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  output logic [31:0] command_in,
  output logic [31:0] spike_0_in,
  output logic [31:0] spike_1_in,
  output logic        command_write,
  output logic        spike_0_write,
  output logic        spike_1_write,
  input  logic        command_read,
  input  logic        spike_0_read,
  input  logic        spike_1_read
);
  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [OCC_W-1:0]   OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0]   OCC_ONE   = OCC_W'(1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic [OCC_W-1:0]   occ_q [3];
  logic [OCC_W-1:0]   occ_d [3];
  logic [31:0]        data_q [3];
  logic [31:0]        data_d [3];
  logic [2:0]         strobe_q, strobe_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               err_q, err_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               readdatavalid_q, readdatavalid_d;

  logic               fifo_sel, target_full, stall, accept, push, drop, clear;
  logic [OCC_W-1:0]   target_occ;
  logic [2:0]         push_vec, pop_vec;

  assign pop_vec = {spike_1_read, spike_0_read, command_read};

  always_comb begin
    fifo_sel = (avs_address != 2'd3);
    case (avs_address)
      2'd0:    target_occ = occ_q[0];
      2'd1:    target_occ = occ_q[1];
      2'd2:    target_occ = occ_q[2];
      default: target_occ = '0;
    endcase
    target_full = fifo_sel && (target_occ == OCC_FULL);
    stall       = avs_write && target_full && (stall_cnt_q != STALL_MAX);
    accept      = avs_write && fifo_sel && !stall;
    // A write still blocked at the timeout completes on the bus but is discarded.
    push        = accept && !target_full;
    drop        = accept && target_full;
    clear       = avs_write && (avs_address == 2'd3) && avs_writedata[0];
    push_vec    = push ? (3'b001 << avs_address) : 3'b000;
  end

  // Stall must vanish the moment reset asserts, not at the next clock.
  assign avs_waitrequest = stall && rst_n;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      occ_d[i]  = occ_q[i];
      data_d[i] = data_q[i];
      if (push_vec[i]) begin
        data_d[i] = avs_writedata;
      end
      if (push_vec[i] && !pop_vec[i]) begin
        occ_d[i] = occ_q[i] + OCC_ONE;
      end else if (!push_vec[i] && pop_vec[i] && (occ_q[i] != '0)) begin
        occ_d[i] = occ_q[i] - OCC_ONE;
      end
    end
    strobe_d    = push_vec;
    stall_cnt_d = stall ? (stall_cnt_q + STALL_ONE) : '0;

    err_d      = err_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      err_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      err_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    readdatavalid_d = avs_read;
    readdata_d      = '0;
    if (avs_read) begin
      case (avs_address)
        2'd0:    readdata_d = 32'(occ_q[0]);
        2'd1:    readdata_d = 32'(occ_q[1]);
        2'd2:    readdata_d = 32'(occ_q[2]);
        default: readdata_d = {err_q, 15'b0, drop_cnt_q};
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        occ_q[i]  <= '0;
        data_q[i] <= '0;
      end
      strobe_q        <= '0;
      stall_cnt_q     <= '0;
      err_q           <= 1'b0;
      drop_cnt_q      <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        occ_q[i]  <= occ_d[i];
        data_q[i] <= data_d[i];
      end
      strobe_q        <= strobe_d;
      stall_cnt_q     <= stall_cnt_d;
      err_q           <= err_d;
      drop_cnt_q      <= drop_cnt_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  assign command_in        = data_q[0];
  assign spike_0_in        = data_q[1];
  assign spike_1_in        = data_q[2];
  assign command_write     = strobe_q[0];
  assign spike_0_write     = strobe_q[1];
  assign spike_1_write     = strobe_q[2];
  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;
endmodule
